// File: rtl/master_port.sv
// master_port: requests the shared bus, shifts out address/write data LSB-first, and collects serial read data.
module master_port #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_read_en,
    input  logic [ADDR_WIDTH-1:0] i_addr_in,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic                  i_bus_grant,
    input  logic                  i_bus_in,
    input  logic                  i_bus_in_valid,
    output logic                  o_bus_req,
    output logic                  o_bus_out,
    output logic                  o_bus_out_valid,
    output logic                  o_bus_mode,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_done,
    output logic                  o_error,
    output logic                  o_busy
);
    localparam int CW = $clog2(ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, REQ, ADDR, WDATA, RDATA, DONE} state_t;

    state_t                r_state, w_state_nx;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_sh;
    logic [DATA_WIDTH-1:0] r_data, w_data_sh, r_shadow, w_shadow_nx;
    logic                  r_mode, w_mode, w_err_nx, w_commit, w_active, w_bit;
    logic [CW-1:0]         r_cnt, w_cnt_nx;
    logic [TW-1:0]         r_tcnt, w_tcnt_nx;

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_tcnt_nx   = r_tcnt;
        w_shadow_nx = r_shadow;
        w_err_nx    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: if (i_enable) w_state_nx = REQ;
            REQ: if (i_bus_grant) begin
                w_state_nx = ADDR;
                w_cnt_nx   = '0;
            end
            ADDR: if (!i_bus_grant) begin
                w_state_nx = DONE;
                w_err_nx   = 1'b1;
            end else if (r_cnt == CW'(ADDR_WIDTH - 1)) begin
                w_state_nx  = r_mode ? RDATA : WDATA;
                w_cnt_nx    = '0;
                w_tcnt_nx   = '0;
                w_shadow_nx = '0;
            end else w_cnt_nx = r_cnt + 1'b1;
            WDATA: if (!i_bus_grant) begin
                w_state_nx = DONE;
                w_err_nx   = 1'b1;
            end else if (r_cnt == CW'(DATA_WIDTH - 1)) w_state_nx = DONE;
            else w_cnt_nx = r_cnt + 1'b1;
            RDATA: begin
                w_tcnt_nx = r_tcnt + 1'b1;
                if (!i_bus_grant) begin
                    w_state_nx = DONE;
                    w_err_nx   = 1'b1;
                end else if (i_bus_in_valid && r_cnt == CW'(DATA_WIDTH - 1)) begin
                    w_shadow_nx = r_shadow | (DATA_WIDTH'(i_bus_in) << r_cnt);
                    w_commit    = 1'b1;
                    w_state_nx  = DONE;
                end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                    w_state_nx = DONE;
                    w_err_nx   = 1'b1;
                end else if (i_bus_in_valid) begin
                    w_shadow_nx = r_shadow | (DATA_WIDTH'(i_bus_in) << r_cnt);
                    w_cnt_nx    = r_cnt + 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state they describe.
    assign w_addr_sh = r_addr >> w_cnt_nx;
    assign w_data_sh = r_data >> w_cnt_nx;
    assign w_active  = w_state_nx inside {REQ, ADDR, WDATA, RDATA};
    assign w_mode    = (r_state == IDLE) ? i_read_en : r_mode;
    assign w_bit     = (w_state_nx == ADDR) ? w_addr_sh[0] : (w_state_nx == WDATA) ? w_data_sh[0] : 1'b0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_data          <= '0;
            r_mode          <= 1'b0;
            r_shadow        <= '0;
            r_cnt           <= '0;
            r_tcnt          <= '0;
            o_bus_req       <= 1'b0;
            o_bus_out       <= 1'b0;
            o_bus_out_valid <= 1'b0;
            o_bus_mode      <= 1'b0;
            o_data_out      <= '0;
            o_done          <= 1'b0;
            o_error         <= 1'b0;
            o_busy          <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_tcnt   <= w_tcnt_nx;
            r_shadow <= w_shadow_nx;
            if (r_state == IDLE && i_enable) begin
                r_addr <= i_addr_in;
                r_data <= i_data_in;
                r_mode <= i_read_en;
            end
            if (w_commit) o_data_out <= w_shadow_nx;
            o_busy          <= w_state_nx != IDLE;
            o_bus_req       <= w_active;
            o_bus_mode      <= w_active & w_mode;
            o_bus_out_valid <= w_state_nx inside {ADDR, WDATA};
            o_bus_out       <= w_bit;
            o_done          <= w_state_nx == DONE;
            o_error         <= w_err_nx;
        end
    end
endmodule

// File: tb/tb_master_port.sv
// tb_master_port: directed-vector bench for master_port with hand-computed expectations.
module tb_master_port;
    logic        clk = 1'b0, reset, enable, read_en, bus_grant, bus_in, bus_in_valid;
    logic [13:0] addr_in;
    logic [7:0]  data_in, data_out, rd;
    logic        bus_req, bus_out, bus_out_valid, bus_mode, done, error, busy;
    logic [6:0]  outs;
    logic [31:0] v;
    int          checks = 0, failures = 0, nv, n, req_cnt, ndone;

    always #5 clk = ~clk;

    master_port dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_read_en(read_en),
        .i_addr_in(addr_in), .i_data_in(data_in), .i_bus_grant(bus_grant),
        .i_bus_in(bus_in), .i_bus_in_valid(bus_in_valid), .o_bus_req(bus_req),
        .o_bus_out(bus_out), .o_bus_out_valid(bus_out_valid), .o_bus_mode(bus_mode),
        .o_data_out(data_out), .o_done(done), .o_error(error), .o_busy(busy)
    );

    assign outs = {busy, bus_req, bus_mode, bus_out_valid, bus_out, done, error};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic start(input logic rd_en, input logic [13:0] a, input logic [7:0] d);
        @(negedge clk);
        enable = 1'b1; read_en = rd_en; addr_in = a; data_in = d;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic collect(input int cnt, output logic [31:0] bits, output int nvalid);
        bits = '0; nvalid = 0;
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            if (bus_out_valid) begin
                bits[i] = bus_out;
                nvalid++;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; enable = 1'b0; read_en = 1'b0; addr_in = '0; data_in = '0;
        bus_grant = 1'b0; bus_in = 1'b0; bus_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", 32'(outs), 32'd0);
        chk("reset_data", 32'(data_out), 32'd0);
        reset = 1'b0;

        // write 1001 / 101, immediate grant
        bus_grant = 1'b1;
        start(1'b0, 14'd1001, 8'd101);
        chk("wr_busy", {29'd0, busy, bus_req, bus_mode}, 32'b110);
        collect(22, v, nv);
        chk("wr_bits", v, {10'd0, 8'd101, 14'd1001});
        chk("wr_nvalid", nv, 22);
        @(negedge clk);
        chk("wr_done", {28'd0, done, error, bus_req, bus_out_valid}, 32'b1000);
        @(negedge clk);
        chk("wr_idle", {30'd0, busy, done}, 32'd0);

        // read 5097, slave returns 101 with one idle gap between bits
        start(1'b1, 14'd5097, 8'd0);
        collect(14, v, nv);
        chk("rd_addr", v, 32'd5097);
        chk("rd_nvalid", nv, 14);
        @(negedge clk);
        chk("rd_phase", {28'd0, bus_out_valid, bus_req, bus_mode, done}, 32'b0110);
        rd = 8'd101;
        for (int i = 0; i < 8; i++) begin
            bus_in_valid = 1'b1; bus_in = rd[i];
            @(negedge clk);
            bus_in_valid = 1'b0; bus_in = 1'b0;
            if (i < 7) @(negedge clk);
        end
        chk("rd_done", {30'd0, done, error}, 32'b10);
        chk("rd_data", 32'(data_out), 32'd101);
        @(negedge clk);
        chk("rd_idle", {30'd0, busy, done}, 32'd0);

        // read 9193 with no slave response
        start(1'b1, 14'd9193, 8'd0);
        collect(14, v, nv);
        chk("to_addr", v, 32'd9193);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        chk("to_cycles", n, 65);
        chk("to_err", 32'(error), 32'd1);
        chk("to_data", 32'(data_out), 32'd101);
        @(negedge clk);

        // delayed grant, enable held while busy
        bus_grant = 1'b0;
        @(negedge clk);
        enable = 1'b1; read_en = 1'b0; addr_in = 14'd3001; data_in = 8'hC3;
        req_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_cnt += int'(bus_req);
        end
        chk("dg_req", req_cnt, 10);
        bus_grant = 1'b1;
        @(negedge clk);
        chk("dg_first", {30'd0, bus_out_valid, bus_out}, 32'b11);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 4) enable = 1'b0;
            ndone += int'(done);
        end
        chk("dg_ndone", ndone, 1);

        // grant drops while data bit 3 is on the bus
        start(1'b0, 14'd1234, 8'hA5);
        collect(17, v, nv);
        @(negedge clk);
        chk("gd_bit3", {30'd0, bus_out_valid, bus_out}, 32'b10);
        bus_grant = 1'b0;
        @(negedge clk);
        chk("gd_done", {29'd0, done, error, bus_out_valid}, 32'b110);
        @(negedge clk);
        chk("gd_idle", {28'd0, busy, bus_req, done, error}, 32'd0);
        chk("gd_data", 32'(data_out), 32'd101);
        bus_grant = 1'b1;

        // reset during read, then a fresh write
        start(1'b1, 14'd77, 8'd0);
        collect(14, v, nv);
        @(negedge clk);
        bus_in_valid = 1'b1; bus_in = 1'b1;
        repeat (2) @(negedge clk);
        bus_in_valid = 1'b0; bus_in = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_outs", 32'(outs), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        reset = 1'b0;
        enable = 1'b1; read_en = 1'b0; addr_in = 14'd1001; data_in = 8'd101;
        @(negedge clk);
        enable = 1'b0;
        chk("rst_accept", {29'd0, busy, bus_req, done}, 32'b110);
        collect(22, v, nv);
        chk("rst_wr_bits", v, {10'd0, 8'd101, 14'd1001});
        @(negedge clk);
        chk("rst_wr_done", {30'd0, done, error}, 32'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
